// File: rtl/instruction_pkg.sv
// Shared instruction types, opcode constants and field-packing helpers
// used by the encoder datapath and its testbench.
package instruction_pkg;

    typedef logic [31:0] instruction_t;
    typedef logic [6:0]  opcode_t;

    localparam opcode_t    UlaIType  = 7'b0010011;
    localparam opcode_t    UlaIWType = 7'b0011011;
    localparam opcode_t    Lui       = 7'b0110111;
    localparam logic [2:0] Funct3Add = 3'b000;
    localparam logic [4:0] RegZero   = 5'd0;

    typedef enum logic [2:0] {
        FmtI  = 3'd0,
        FmtS  = 3'd1,
        FmtB  = 3'd2,
        FmtU  = 3'd3,
        FmtJ  = 3'd4,
        FmtLI = 3'd5
    } format_t;

    function automatic instruction_t encodeI(input logic [11:0] imm, input logic [4:0] rs1,
                                             input logic [2:0] f3, input logic [4:0] rd,
                                             input opcode_t op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic instruction_t encodeS(input logic [11:0] imm, input logic [4:0] rs2,
                                             input logic [4:0] rs1, input logic [2:0] f3,
                                             input opcode_t op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    // Branch and jump offsets are always even, so bit 0 is never passed in.
    function automatic instruction_t encodeB(input logic [12:1] imm, input logic [4:0] rs2,
                                             input logic [4:0] rs1, input logic [2:0] f3,
                                             input opcode_t op);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    endfunction

    function automatic instruction_t encodeU(input logic [19:0] imm, input logic [4:0] rd,
                                             input opcode_t op);
        return {imm, rd, op};
    endfunction

    function automatic instruction_t encodeJ(input logic [20:1] imm, input logic [4:0] rd,
                                             input opcode_t op);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
    endfunction

endpackage

// File: rtl/li_splitter.sv
// Splits a load-immediate value into a LUI upper part and a 12-bit signed
// low part, and reports whether the value is reachable with LUI+ADDI(W).
module li_splitter
    import instruction_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] imm_i,
    output logic         fits12_o,
    output logic         range_ok_o,
    output logic         lo_zero_o,
    output logic [19:0]  hi_o,
    output logic [11:0]  lo_o
);

    // Adding 0x800 before taking [31:12] only ever carries in imm[11], so the
    // rounding is done as a 20-bit increment instead of a full 32-bit add.
    always_comb begin
        fits12_o   = (&imm_i[N-1:11]) | ~(|imm_i[N-1:11]);
        range_ok_o = (&imm_i[N-1:31]) | ~(|imm_i[N-1:31]);
        hi_o       = imm_i[31:12] + {19'd0, imm_i[11]};
        lo_o       = imm_i[11:0];
        lo_zero_o  = (imm_i[11:0] == 12'd0);
    end

endmodule

// File: rtl/instruction_encoder.sv
// Packs instruction fields and immediates into 32-bit words and streams them
// out with valid/ready handshakes; LI may expand into a LUI + ADDI(W) pair.
module instruction_encoder
    import instruction_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  format_t      req_format,
    input  logic [6:0]   req_opcode,
    input  logic [2:0]   req_funct3,
    input  logic [4:0]   req_rd,
    input  logic [4:0]   req_rs1,
    input  logic [4:0]   req_rs2,
    input  logic [N-1:0] req_imm,
    output logic         out_valid,
    input  logic         out_ready,
    output instruction_t out_instruction,
    output logic         out_last,
    output logic         out_error
);

    localparam opcode_t AddiOp = (N == 64) ? UlaIWType : UlaIType;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLast  = 2'd1,
        StFirst = 2'd2
    } state_t;

    state_t       state_q, state_d;
    instruction_t instr_q, instr_d;
    instruction_t staged_q, staged_d;
    logic         error_q, error_d;

    logic         fitsI, fitsB, fitsJ, fitsU;
    logic         liFits12, liRangeOk, liLoZero;
    logic [19:0]  liHi;
    logic [11:0]  liLo;
    instruction_t encWord, encStaged;
    logic         encError, encTwoBeat;
    logic         accept;

    li_splitter #(.N(N)) u_li_splitter (
        .imm_i      (req_imm),
        .fits12_o   (liFits12),
        .range_ok_o (liRangeOk),
        .lo_zero_o  (liLoZero),
        .hi_o       (liHi),
        .lo_o       (liLo)
    );

    always_comb begin
        fitsI = (&req_imm[N-1:11]) | ~(|req_imm[N-1:11]);
        fitsB = ((&req_imm[N-1:12]) | ~(|req_imm[N-1:12])) & ~req_imm[0];
        fitsJ = ((&req_imm[N-1:20]) | ~(|req_imm[N-1:20])) & ~req_imm[0];
        fitsU = ((&req_imm[N-1:31]) | ~(|req_imm[N-1:31])) & (req_imm[11:0] == 12'd0);
    end

    // Any illegal request collapses to a single zero word flagged as an error.
    always_comb begin
        encWord    = '0;
        encStaged  = '0;
        encError   = 1'b0;
        encTwoBeat = 1'b0;
        case (req_format)
            FmtI: begin
                if (fitsI) encWord = encodeI(req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode);
                else       encError = 1'b1;
            end
            FmtS: begin
                if (fitsI) encWord = encodeS(req_imm[11:0], req_rs2, req_rs1, req_funct3, req_opcode);
                else       encError = 1'b1;
            end
            FmtB: begin
                if (fitsB) encWord = encodeB(req_imm[12:1], req_rs2, req_rs1, req_funct3, req_opcode);
                else       encError = 1'b1;
            end
            FmtU: begin
                if (fitsU) encWord = encodeU(req_imm[31:12], req_rd, req_opcode);
                else       encError = 1'b1;
            end
            FmtJ: begin
                if (fitsJ) encWord = encodeJ(req_imm[20:1], req_rd, req_opcode);
                else       encError = 1'b1;
            end
            FmtLI: begin
                if (!liRangeOk) begin
                    encError = 1'b1;
                end else if (liFits12) begin
                    encWord = encodeI(liLo, RegZero, Funct3Add, req_rd, UlaIType);
                end else begin
                    encWord = encodeU(liHi, req_rd, Lui);
                    if (!liLoZero) begin
                        encTwoBeat = 1'b1;
                        encStaged  = encodeI(liLo, req_rd, Funct3Add, req_rd, AddiOp);
                    end
                end
            end
            default: encError = 1'b1;
        endcase
    end

    assign req_ready = reset_n & ((state_q == StIdle) | ((state_q == StLast) & out_ready));
    assign accept    = req_valid & req_ready;

    // A held beat only changes when it transfers; new requests load on accept.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        staged_d = staged_q;
        error_d  = error_q;
        case (state_q)
            StIdle, StLast: begin
                if (accept) begin
                    instr_d  = encWord;
                    staged_d = encStaged;
                    error_d  = encError;
                    state_d  = encTwoBeat ? StFirst : StLast;
                end else if ((state_q == StLast) && out_ready) begin
                    state_d = StIdle;
                end
            end
            StFirst: begin
                if (out_ready) begin
                    instr_d = staged_q;
                    error_d = 1'b0;
                    state_d = StLast;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            instr_q  <= '0;
            staged_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            staged_q <= staged_d;
            error_q  <= error_d;
        end
    end

    assign out_valid       = (state_q != StIdle);
    assign out_last        = (state_q == StLast);
    assign out_error       = error_q;
    assign out_instruction = instr_q;

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock. All state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the request is valid.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the encoder accepts a request.
REQ-006 The block SHALL have port req_format, input, format_t: one of I, S, B, U, J, LI.
REQ-007 The block SHALL have ports req_opcode (7 bits), req_funct3 (3 bits), req_rd (5 bits), req_rs1 (5 bits) and req_rs2 (5 bits), all inputs: the instruction fields. For LI, only req_rd is used.
REQ-008 The block SHALL have port req_imm, input, N bits: the signed immediate.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-011 The block SHALL have port out_instruction, output, instruction_t (32 bits): the encoded word.
REQ-012 The block SHALL have port out_last, output, 1 bit: final beat of the request.
REQ-013 The block SHALL have port out_error, output, 1 bit: the immediate is not encodable; out_instruction SHALL be 0 in that beat.

Function
REQ-014 A request transfers when req_valid && req_ready at a rising edge. Its first beat SHALL be presented with out_valid=1 from the next cycle (latency 1).
REQ-015 A beat transfers when out_valid && out_ready. While a beat is held, out_* SHALL remain stable until it transfers.
REQ-016 req_ready SHALL be (state==IDLE) || (state==LAST && out_ready), giving back-to-back throughput of one beat per cycle.
REQ-017 The FSM SHALL have three states:
- IDLE: no beat held.
- LAST: the held beat has out_last=1.
- FIRST: holds the LUI of an LI pair, with the ADDI/ADDIW staged.
REQ-018 The FSM transitions SHALL be:
- IDLE or LAST → LAST or FIRST on accept.
- LAST → IDLE on transfer without a new accept.
- FIRST → LAST on transfer.
REQ-019 I and S formats: the immediate SHALL fit 12-bit signed. Bit placement is the inverse of the immediate extender's I and S layouts.
REQ-020 B format: the immediate SHALL fit 13-bit signed with bit0=0. J format: the immediate SHALL fit 21-bit signed with bit0=0.
REQ-021 U format: the immediate SHALL have imm[11:0]=0 and be the sign-extension of imm[31:0]. Field = imm[31:12].
REQ-022 LI, when the immediate fits 12-bit signed: emit one beat, ADDI rd,x0,imm (opcode UlaIType, funct3 0).
REQ-023 LI otherwise: hi = (imm + 0x800)[31:12] and lo = imm − (hi<<12), in 12 bits.
- Emit LUI rd,hi.
- If lo≠0, then emit a second beat, ADDI rd,rd,lo (N=32) or ADDIW rd,rd,lo (N=64, opcode UlaIWType).
- If lo=0, emit LUI only, with out_last=1.
REQ-024 LI with N=64: an immediate that is not the sign-extension of its bit 31 SHALL produce an error beat.
REQ-025 Any range or alignment violation SHALL produce exactly one beat with out_error=1, out_last=1, out_instruction=0.
REQ-026 The block SHALL not alter the format or fields of a held beat; new requests SHALL be sampled only on accept.

Reset
REQ-027 While reset_n=0, the block SHALL hold state=IDLE, out_valid=0, out_last=0, out_error=0, out_instruction=0 and req_ready=0.
REQ-028 Reset asserted mid-pair SHALL discard both the held and the staged beat; no beat of that request is emitted after reset release.
REQ-029 req_ready SHALL rise in the first cycle after reset_n deasserts.

Structure
REQ-030 format_t SHALL be added to instruction_pkg. Opcode constants (UlaIType, UlaIWType, Lui, etc.) and instruction_t are reused from instruction_pkg; no local opcode literals.
REQ-031 The LI hi/lo split and range check SHALL be one combinational sub-module, li_splitter; field packing and the FSM stay in instruction_encoder.

Verification
REQ-032 LI, rd=5, imm=0x12345678, N=32 SHALL produce 0x123452B7 (last=0), then 0x67828293 (last=1).
REQ-033 LI, rd=5, imm=0xFFFFF800 SHALL produce a single beat, 0x80000293, last=1. LI with imm=0x00000FFF SHALL produce 0x000012B7, then 0xFFF28293.
REQ-034 B, opcode 0x63, funct3 0, rs1=1, rs2=2, imm=−4 SHALL produce 0xFE208EE3. The same request with imm=3 SHALL produce an error beat (out_error=1, instruction 0).
REQ-035 Hold out_ready=0 for 3 cycles during an LI pair: the LUI SHALL stay stable and req_ready SHALL stay 0. After release, the ADDI SHALL follow; a queued I request SHALL then be accepted in the cycle the ADDI transfers.
REQ-036 Assert reset_n=0 while in FIRST: out_valid SHALL drop immediately. After release, no ADDI SHALL appear and req_ready SHALL be 1.
